// File: rtl/inst_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer_if
// Description : Fetch-side push bus and decode-side dequeue bus of inst_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_buffer_if #(
    parameter int DEPTH = 16
) ();
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    // Fetch / predictor side
    logic               flush;
    logic               is_valid_in;
    logic               push_en_1;
    logic               push_en_2;
    logic [31:0]        pc_1;
    logic [31:0]        pc_2;
    logic [31:0]        inst_1;
    logic [31:0]        inst_2;
    logic               pred_taken;
    logic [31:0]        pred_addr;
    logic               full;

    // Decode side
    logic               deq_ready_1;
    logic               deq_ready_2;
    logic               out_valid_1;
    logic               out_valid_2;
    logic [31:0]        out_pc_1;
    logic [31:0]        out_pc_2;
    logic [31:0]        out_inst_1;
    logic [31:0]        out_inst_2;
    logic               out_pred_taken_1;
    logic               out_pred_taken_2;
    logic [31:0]        out_pred_addr_1;
    logic [31:0]        out_pred_addr_2;

    // Status
    logic [c_cnt_w-1:0] count;
    logic [31:0]        stat_full_cycles;
    logic [31:0]        stat_flushes;

    modport master (
        output flush, is_valid_in, push_en_1, push_en_2,
        output pc_1, pc_2, inst_1, inst_2, pred_taken, pred_addr,
        output deq_ready_1, deq_ready_2,
        input  full, count, stat_full_cycles, stat_flushes,
        input  out_valid_1, out_valid_2, out_pc_1, out_pc_2,
        input  out_inst_1, out_inst_2, out_pred_taken_1, out_pred_taken_2,
        input  out_pred_addr_1, out_pred_addr_2
    );

    modport slave (
        input  flush, is_valid_in, push_en_1, push_en_2,
        input  pc_1, pc_2, inst_1, inst_2, pred_taken, pred_addr,
        input  deq_ready_1, deq_ready_2,
        output full, count, stat_full_cycles, stat_flushes,
        output out_valid_1, out_valid_2, out_pc_1, out_pc_2,
        output out_inst_1, out_inst_2, out_pred_taken_1, out_pred_taken_2,
        output out_pred_addr_1, out_pred_addr_2
    );
endinterface
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer
// Description : Dual-issue FWFT instruction queue between fetch and decode.
//               Optional statistics counters: define INST_BUFFER_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_buffer #(
    parameter int DEPTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    inst_buffer_if.slave     bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_thresh = c_cnt_w'(DEPTH - 2);
    localparam logic [c_cnt_w-1:0] c_two         = c_cnt_w'(2);

    // Reset asserts asynchronously; its release is retimed to clk.
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    logic [31:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_inst_mem [DEPTH];
    logic               r_pt_mem   [DEPTH];
    logic [31:0]        r_pa_mem   [DEPTH];

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic               w_full;
    logic               w_valid_1;
    logic               w_valid_2;
    logic               w_push;
    logic [1:0]         w_n_push;
    logic               w_pop_1;
    logic               w_pop_2;
    logic [1:0]         w_n_pop;
    logic [c_ptr_w-1:0] w_head_1;
    logic [c_ptr_w-1:0] w_tail_1;
    logic               w_pt_slot_1;
    logic [31:0]        w_pa_slot_1;

    assign w_full    = (r_count > c_full_thresh);
    assign w_valid_1 = (r_count != '0);
    assign w_valid_2 = (r_count >= c_two);

    assign w_push   = bus.is_valid_in & bus.push_en_1 & ~w_full & ~bus.flush;
    assign w_n_push = w_push ? (bus.push_en_2 ? 2'd2 : 2'd1) : 2'd0;

    assign w_pop_1 = w_valid_1 & bus.deq_ready_1;
    assign w_pop_2 = w_pop_1 & w_valid_2 & bus.deq_ready_2;
    assign w_n_pop = {1'b0, w_pop_1} + {1'b0, w_pop_2};

    assign w_head_1 = r_head + c_ptr_w'(1);
    assign w_tail_1 = r_tail + c_ptr_w'(1);

    // The prediction belongs to whichever entry closes the fetch group.
    assign w_pt_slot_1 = bus.push_en_2 ? 1'b0  : bus.pred_taken;
    assign w_pa_slot_1 = bus.push_en_2 ? 32'd0 : bus.pred_addr;

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_ptr_w'(w_n_pop);
            r_tail  <= r_tail + c_ptr_w'(w_n_push);
            r_count <= r_count + c_cnt_w'(w_n_push) - c_cnt_w'(w_n_pop);
        end
    end

    // Payload storage needs no reset: outputs are masked by the valids.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= bus.pc_1;
            r_inst_mem[r_tail] <= bus.inst_1;
            r_pt_mem[r_tail]   <= w_pt_slot_1;
            r_pa_mem[r_tail]   <= w_pa_slot_1;
            if (bus.push_en_2) begin
                r_pc_mem[w_tail_1]   <= bus.pc_2;
                r_inst_mem[w_tail_1] <= bus.inst_2;
                r_pt_mem[w_tail_1]   <= bus.pred_taken;
                r_pa_mem[w_tail_1]   <= bus.pred_addr;
            end
        end
    end

    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.out_valid_1 = w_valid_1;
    assign bus.out_valid_2 = w_valid_2;

    assign bus.out_pc_1         = w_valid_1 ? r_pc_mem[r_head]     : 32'd0;
    assign bus.out_inst_1       = w_valid_1 ? r_inst_mem[r_head]   : 32'd0;
    assign bus.out_pred_taken_1 = w_valid_1 ? r_pt_mem[r_head]     : 1'b0;
    assign bus.out_pred_addr_1  = w_valid_1 ? r_pa_mem[r_head]     : 32'd0;
    assign bus.out_pc_2         = w_valid_2 ? r_pc_mem[w_head_1]   : 32'd0;
    assign bus.out_inst_2       = w_valid_2 ? r_inst_mem[w_head_1] : 32'd0;
    assign bus.out_pred_taken_2 = w_valid_2 ? r_pt_mem[w_head_1]   : 1'b0;
    assign bus.out_pred_addr_2  = w_valid_2 ? r_pa_mem[w_head_1]   : 32'd0;

`ifdef INST_BUFFER_STAT_EN
    logic [31:0] r_stat_full_cycles;
    logic [31:0] r_stat_flushes;

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_stat_full_cycles <= '0;
            r_stat_flushes     <= '0;
        end else begin
            if (w_full && (r_stat_full_cycles != '1)) begin
                r_stat_full_cycles <= r_stat_full_cycles + 32'd1;
            end
            if (bus.flush && (r_stat_flushes != '1)) begin
                r_stat_flushes <= r_stat_flushes + 32'd1;
            end
        end
    end

    assign bus.stat_full_cycles = r_stat_full_cycles;
    assign bus.stat_flushes     = r_stat_flushes;
`else
    assign bus.stat_full_cycles = 32'd0;
    assign bus.stat_flushes     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_buffer
// Description : Directed, table-driven self-checking bench for inst_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_buffer_if #(.DEPTH(DEPTH)) bus ();

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fl, vin, pe1, pe2;
        logic [31:0] pc1, pc2;
        logic        pt;
        logic [31:0] pa;
        logic        dr1, dr2;
        int          e_cnt;
        logic        e_full, e_v1, e_v2;
        logic [31:0] e_pc1, e_pc2;
        logic        e_pt1, e_pt2;
        logic [31:0] e_pa1, e_pa2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int e_cnt, input logic e_full,
                               input logic e_v1, input logic e_v2,
                               input logic [31:0] e_pc1, input logic [31:0] e_pc2,
                               input logic e_pt1, input logic e_pt2,
                               input logic [31:0] e_pa1, input logic [31:0] e_pa2);
        check({tag, ".count"}, 32'(bus.count), 32'(e_cnt));
        check({tag, ".full"},  32'(bus.full), 32'(e_full));
        check({tag, ".v1"},    32'(bus.out_valid_1), 32'(e_v1));
        check({tag, ".v2"},    32'(bus.out_valid_2), 32'(e_v2));
        check({tag, ".pc1"},   bus.out_pc_1, e_pc1);
        check({tag, ".pc2"},   bus.out_pc_2, e_pc2);
        check({tag, ".inst1"}, bus.out_inst_1, e_v1 ? ~e_pc1 : 32'd0);
        check({tag, ".inst2"}, bus.out_inst_2, e_v2 ? ~e_pc2 : 32'd0);
        check({tag, ".pt1"},   32'(bus.out_pred_taken_1), 32'(e_pt1));
        check({tag, ".pt2"},   32'(bus.out_pred_taken_2), 32'(e_pt2));
        check({tag, ".pa1"},   bus.out_pred_addr_1, e_pa1);
        check({tag, ".pa2"},   bus.out_pred_addr_2, e_pa2);
    endtask

    // Instruction words are the inverted PC so the payload path is checked too.
    task automatic drive(input logic fl, input logic vin, input logic pe1, input logic pe2,
                         input logic [31:0] pc1, input logic [31:0] pc2,
                         input logic pt, input logic [31:0] pa,
                         input logic dr1, input logic dr2);
        bus.flush       = fl;
        bus.is_valid_in = vin;
        bus.push_en_1   = pe1;
        bus.push_en_2   = pe2;
        bus.pc_1        = pc1;
        bus.pc_2        = pc2;
        bus.inst_1      = ~pc1;
        bus.inst_2      = ~pc2;
        bus.pred_taken  = pt;
        bus.pred_addr   = pa;
        bus.deq_ready_1 = dr1;
        bus.deq_ready_2 = dr2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] head_pc;
        logic [31:0] next_pc;

        vecs[0] = '{0,1,1,1, 32'h1c000000,32'h1c000004,1,32'h1c000100,0,0,
                    2,0,1,1, 32'h1c000000,32'h1c000004,0,1,32'h0,32'h1c000100};
        vecs[1] = '{0,1,0,1, 32'h00002000,32'h00002004,1,32'h00000bad,0,0,
                    2,0,1,1, 32'h1c000000,32'h1c000004,0,1,32'h0,32'h1c000100};
        vecs[2] = '{0,0,1,1, 32'h00003000,32'h00003004,1,32'h00000bad,0,0,
                    2,0,1,1, 32'h1c000000,32'h1c000004,0,1,32'h0,32'h1c000100};
        vecs[3] = '{0,1,1,0, 32'h1c000008,32'h00000000,1,32'h1c000200,0,0,
                    3,0,1,1, 32'h1c000000,32'h1c000004,0,1,32'h0,32'h1c000100};
        vecs[4] = '{0,0,0,0, 32'h0,32'h0,0,32'h0,0,1,
                    3,0,1,1, 32'h1c000000,32'h1c000004,0,1,32'h0,32'h1c000100};
        vecs[5] = '{0,0,0,0, 32'h0,32'h0,0,32'h0,1,0,
                    2,0,1,1, 32'h1c000004,32'h1c000008,1,1,32'h1c000100,32'h1c000200};
        vecs[6] = '{0,1,1,1, 32'h1c00000c,32'h1c000010,0,32'h1c000300,1,1,
                    2,0,1,1, 32'h1c00000c,32'h1c000010,0,0,32'h0,32'h1c000300};
        vecs[7] = '{0,0,0,0, 32'h0,32'h0,0,32'h0,1,1,
                    0,0,0,0, 32'h0,32'h0,0,0,32'h0,32'h0};
        vecs[8] = '{0,0,0,0, 32'h0,32'h0,0,32'h0,1,1,
                    0,0,0,0, 32'h0,32'h0,0,0,32'h0,32'h0};

        rst = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.stat_full", bus.stat_full_cycles, 32'd0);
        check("reset.stat_flush", bus.stat_flushes, 32'd0);
        rst = 1'b1;
        repeat (3) step();
        check_state("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].fl, vecs[i].vin, vecs[i].pe1, vecs[i].pe2, vecs[i].pc1, vecs[i].pc2,
                  vecs[i].pt, vecs[i].pa, vecs[i].dr1, vecs[i].dr2);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_v1,
                        vecs[i].e_v2, vecs[i].e_pc1, vecs[i].e_pc2, vecs[i].e_pt1,
                        vecs[i].e_pt2, vecs[i].e_pa1, vecs[i].e_pa2);
        end

        // Fill to the full threshold and beyond.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 1, 1, 32'h40000000 + 32'(8*k), 32'h40000004 + 32'(8*k), 0, 32'h0, 0, 0);
            step();
            check($sformatf("fill%0d.count", k), 32'(bus.count), 32'(2*(k+1)));
            check($sformatf("fill%0d.full", k), 32'(bus.full), (k == 7) ? 32'd1 : 32'd0);
        end
        drive(0, 1, 1, 1, 32'h50000000, 32'h50000004, 0, 32'h0, 0, 0);
        step();
        check("refused.count", 32'(bus.count), 32'd16);
        check("refused.full", 32'(bus.full), 32'd1);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0);
        step();
        check("pop15.count", 32'(bus.count), 32'd15);
        check("pop15.full", 32'(bus.full), 32'd1);
        check("pop15.pc1", bus.out_pc_1, 32'h40000004);
        step();
        check("pop14.count", 32'(bus.count), 32'd14);
        check("pop14.full", 32'(bus.full), 32'd0);
        check("pop14.pc1", bus.out_pc_1, 32'h40000008);
        check("pop14.pc2", bus.out_pc_2, 32'h4000000c);
`ifdef INST_BUFFER_STAT_EN
        check("stat_full_cycles", bus.stat_full_cycles, 32'd3);
`else
        check("stat_full_cycles", bus.stat_full_cycles, 32'd0);
`endif

        // Drain to nine entries, then flush with a simultaneous push and pop.
        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1);
        step();
        check("drain12.pc1", bus.out_pc_1, 32'h40000010);
        step();
        check("drain10.pc1", bus.out_pc_1, 32'h40000018);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0);
        step();
        check("drain9.count", 32'(bus.count), 32'd9);
        check("drain9.pc1", bus.out_pc_1, 32'h4000001c);
        drive(1, 1, 1, 1, 32'h70000000, 32'h70000004, 1, 32'h70000100, 1, 1);
        step();
        idle();
        check_state("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef INST_BUFFER_STAT_EN
        check("stat_flushes", bus.stat_flushes, 32'd1);
`else
        check("stat_flushes", bus.stat_flushes, 32'd0);
`endif

        // Steady two-in/two-out stream wraps the pointers several times.
        head_pc = 32'h60000000;
        drive(0, 1, 1, 1, head_pc, head_pc + 32'd4, 0, 32'h0, 0, 0);
        step();
        check("wrap0.pc1", bus.out_pc_1, head_pc);
        next_pc = head_pc + 32'd8;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 1, next_pc, next_pc + 32'd4, 0, 32'h0, 1, 1);
            step();
            next_pc = next_pc + 32'd8;
            head_pc = head_pc + 32'd8;
            check($sformatf("wrap%0d.count", i), 32'(bus.count), 32'd2);
            check($sformatf("wrap%0d.pc1", i), bus.out_pc_1, head_pc);
            check($sformatf("wrap%0d.pc2", i), bus.out_pc_2, head_pc + 32'd4);
            check($sformatf("wrap%0d.inst2", i), bus.out_inst_2, ~(head_pc + 32'd4));
        end
        idle();

        // Reset mid-operation clears the queue without waiting for an edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.count", 32'(bus.count), 32'd0);
        check("async_rst.v1", 32'(bus.out_valid_1), 32'd0);
        check("async_rst.pc1", bus.out_pc_1, 32'd0);
        rst = 1'b1;
        repeat (3) step();
        check_state("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
